memory_line_arbiter: RTL
========================

# memory_line_arbiter

Shares the single main-memory line port between the L1 instruction cache (port 0) and the L1 data cache (port 1). It accepts whole-line LOAD/STORE requests from either cache with valid/ready handshakes and grants them round-robin. It keeps exactly one transaction outstanding to memory and routes the memory response back to the originating cache. It sits between the two L1 cache controllers (their WRITEBACK/FILL states) and the memory interface.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters; fixed at 2 in this revision.
- LINE_WIDTH, LINE_SIZE (100), bits per line (4 x 25-bit words).
- ADDR_WIDTH, MEMORY_LINE_ADDRESS_WIDTH (23), line address width.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- req_valid_in  input  [1:0]  per-port request valid.
- req_ready_out  output  [1:0]  per-port request accepted this cycle.
- req_op_in  input  [1:0]  per-port MemoryOperation (0=LOAD, 1=STORE).
- req_addr_in  input  [1:0][ADDR_WIDTH-1:0]  per-port line address.
- req_data_in  input  [1:0][LINE_WIDTH-1:0]  per-port store line.
- resp_valid_out  output  [1:0]  one-cycle completion pulse to the owning port.
- resp_data_out  output  LINE_WIDTH  load line, shared by both ports, qualified by resp_valid_out.
- mem_req_valid_out  output  1  request to memory.
- mem_req_ready_in  input  1  memory accepts the request.
- mem_req_op_out  output  1  MemoryOperation.
- mem_req_addr_out  output  ADDR_WIDTH  line address.
- mem_req_data_out  output  LINE_WIDTH  store line.
- mem_resp_valid_in  input  1  memory completion: load data or store ack.
- mem_resp_data_in  input  LINE_WIDTH  load line.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - req_ready_out = grant vector, combinational from req_valid_in and last_grant. At most one bit is set.
  - When the handshake completes, the arbiter latches op, addr, data and owner, updates last_grant to owner, and moves to ISSUE.
- Grant rule:
  - A sole requester wins.
  - If both request, the port != last_grant wins.
- ISSUE:
  - mem_req_valid_out = 1 with the latched fields held stable.
  - When mem_req_valid_out && mem_req_ready_in, move to WAIT_RESP.
- WAIT_RESP:
  - On mem_resp_valid_in, register resp_data_out <= mem_resp_data_in.
  - Pulse resp_valid_out[owner] for one cycle and return to IDLE.
  - STORE completes the same way. resp_data_out is don't-care for STORE but is still updated from the bus.
- A mem_resp_valid_in outside WAIT_RESP is ignored.
- req_ready_out is 0 in ISSUE and WAIT_RESP. Requesters hold valid and fields stable until they see ready.
- Reset values:
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All valid/ready outputs are 0; resp_data_out, mem_req_addr_out and mem_req_data_out are 0.
- Reset mid-transaction abandons it: no response is issued, and a late mem_resp_valid_in after reset is ignored.

## Timing
- Cycle N: request handshake in IDLE.
- N+1: mem_req_valid_out rises, at the earliest.
- M: mem_req_ready_in while in ISSUE. The state moves to WAIT_RESP at M+1.
- K: mem_resp_valid_in while in WAIT_RESP.
- K+1: resp_valid_out pulses, the state is IDLE, and a new request can be accepted in that same cycle.
- Minimum turnaround is 3 cycles per transaction: accept, issue with immediate ready, response in the cycle after issue.
- Memory responding in the same cycle as it accepts is not permitted; the response is expected at M+1 or later.
- Back-to-back contention alternates grants: 0,1,0,1,...

## Configuration
- MEMORY_LINE_ARBITER_PERF_COUNTERS_EN defined:
  - Adds outputs grant_count_0_out and grant_count_1_out, each 32 bits.
  - Each counter increments on its port's request handshake and saturates at 2^32-1.
  - Reset value 0.
- Not defined: the counter ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Add to cache_help:
  - MemoryLineArbiterState enum {IDLE, ISSUE, WAIT_RESP}.
  - MainMemoryRequest struct {MemoryOperation op; MemoryLineAddress line_address; Line data}.
- Reuse the existing MemoryOperation, Line and MemoryLineAddress types.
- Sub-module rr_arbiter:
  - Holds the last_grant register plus the combinational grant vector.
  - Inputs: request vector and an advance strobe.

## Test plan
- Port 0 only, LOAD addr 0x000010, memory ready immediately, response data 0xAAA.. 1 cycle later -> mem_req_valid at N+1 with addr 0x000010; resp_valid_out=2'b01 at K+1 with resp_data_out=0xAAA...
- Both ports request out of reset -> port 0 granted first, port 1 granted on the next IDLE; the two mem_req_addr_out values appear in order 0 then 1.
- Port 1 STORE addr 0x7FFFFF, data all-ones, mem_req_ready held low 5 cycles -> mem_req fields stable for all 6 cycles; ack gives resp_valid_out=2'b10.
- Spurious mem_resp_valid_in in IDLE -> no resp_valid_out pulse, state unchanged.
- rst_in asserted during WAIT_RESP, then a late mem_resp_valid_in -> all outputs 0 and no response pulse; next tie grants port 0.
- With MEMORY_LINE_ARBITER_PERF_COUNTERS_EN: 3 grants port 0 and 2 grants port 1 -> grant_count_0_out=3, grant_count_1_out=2.

Source files
------------

// File: rtl/memory_line_arbiter_pkg.sv
// Shared cache/memory types plus the arbiter's state enum and latched request struct.
// Line = 4 x 25-bit words; line addresses are 23 bits.
package memory_line_arbiter_pkg;

  localparam int LINE_SIZE                 = 100;
  localparam int MEMORY_LINE_ADDRESS_WIDTH = 23;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } MemoryOperation;

  typedef logic [LINE_SIZE-1:0]                 Line;
  typedef logic [MEMORY_LINE_ADDRESS_WIDTH-1:0] MemoryLineAddress;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } MemoryLineArbiterState;

  typedef struct packed {
    MemoryOperation   op;
    MemoryLineAddress line_address;
    Line              data;
  } MainMemoryRequest;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/memory_line_arbiter_rr_arbiter.sv
// Two-port round-robin grant: combinational one-hot grant, last_grant updated on advance.
// Zero latency; grant is only a proposal, the caller decides when it is taken.
module memory_line_arbiter_rr_arbiter (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [1:0] req_in,
  input  logic       advance_in,
  output logic [1:0] grant_out
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_out    = 2'b00;
    last_grant_d = last_grant_q;
    case (req_in)
      2'b01:   grant_out = 2'b01;
      2'b10:   grant_out = 2'b10;
      2'b11:   grant_out = last_grant_q ? 2'b01 : 2'b10;
      default: grant_out = 2'b00;
    endcase
    if (advance_in && (grant_out != 2'b00)) begin
      last_grant_d = grant_out[1];
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/memory_line_arbiter.sv
// Round-robin share of the memory line port between I$ (port 0) and D$ (port 1), one transaction outstanding.
// Accept -> issue -> response, 3 cycles minimum; optional grant counters under MEMORY_LINE_ARBITER_PERF_COUNTERS_EN.
module memory_line_arbiter
  import memory_line_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = LINE_SIZE,
  parameter int ADDR_WIDTH = MEMORY_LINE_ADDRESS_WIDTH
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_PORTS-1:0]                 req_valid_in,
  output logic [NUM_PORTS-1:0]                 req_ready_out,
  input  logic [NUM_PORTS-1:0]                 req_op_in,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_data_in,
  output logic [NUM_PORTS-1:0]                 resp_valid_out,
  output logic [LINE_WIDTH-1:0]                resp_data_out,
  output logic                                 mem_req_valid_out,
  input  logic                                 mem_req_ready_in,
  output logic                                 mem_req_op_out,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_out,
  output logic [LINE_WIDTH-1:0]                mem_req_data_out,
  input  logic                                 mem_resp_valid_in,
  input  logic [LINE_WIDTH-1:0]                mem_resp_data_in
`ifdef MEMORY_LINE_ARBITER_PERF_COUNTERS_EN
  ,
  output logic [31:0]                          grant_count_0_out,
  output logic [31:0]                          grant_count_1_out
`endif
);

  MemoryLineArbiterState state_q, state_d;
  MainMemoryRequest      req_q, req_d;
  logic                  owner_q, owner_d;
  logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [1:0]            resp_valid_q, resp_valid_d;
  logic [1:0]            arb_req;
  logic [1:0]            grant;

  // Requests are only presented to the arbiter while IDLE, so grant doubles as req_ready.
  assign arb_req = (state_q == IDLE) ? req_valid_in : 2'b00;

  memory_line_arbiter_rr_arbiter u_rr_arbiter (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .req_in     (arb_req),
    .advance_in (state_q == IDLE),
    .grant_out  (grant)
  );

  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    owner_d           = owner_q;
    resp_data_d       = resp_data_q;
    resp_valid_d      = 2'b00;
    req_ready_out     = 2'b00;
    mem_req_valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_out = grant;
        if (grant != 2'b00) begin
          owner_d            = grant[1];
          req_d.op           = MemoryOperation'(req_op_in[grant[1]]);
          req_d.line_address = req_addr_in[grant[1]];
          req_d.data         = req_data_in[grant[1]];
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid_out = 1'b1;
        if (mem_req_ready_in) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid_in) begin
          resp_data_d           = mem_resp_data_in;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      resp_data_q  <= '0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid_out   = resp_valid_q;
  assign resp_data_out    = resp_data_q;
  assign mem_req_op_out   = req_q.op;
  assign mem_req_addr_out = req_q.line_address;
  assign mem_req_data_out = req_q.data;

`ifdef MEMORY_LINE_ARBITER_PERF_COUNTERS_EN
  logic [31:0] grant_count_0_q, grant_count_0_d;
  logic [31:0] grant_count_1_q, grant_count_1_d;

  always_comb begin
    grant_count_0_d = grant_count_0_q;
    grant_count_1_d = grant_count_1_q;
    if (req_valid_in[0] && req_ready_out[0]) grant_count_0_d = sat_inc32(grant_count_0_q);
    if (req_valid_in[1] && req_ready_out[1]) grant_count_1_d = sat_inc32(grant_count_1_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_count_0_q <= '0;
      grant_count_1_q <= '0;
    end else begin
      grant_count_0_q <= grant_count_0_d;
      grant_count_1_q <= grant_count_1_d;
    end
  end

  assign grant_count_0_out = grant_count_0_q;
  assign grant_count_1_out = grant_count_1_q;
`endif

endmodule
